// File: rtl/ber_exp_pkg.sv
// Shared types and constants for the BerExp sampler: FSM state encoding and fixed widths.
package ber_exp_pkg;

  localparam int Z_WIDTH   = 64;
  localparam int S_MAX     = 63;
  localparam int NUM_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    ZCALC,
    CMP,
    OUT
  } state_t;

endpackage

// File: rtl/ber_exp_zcalc.sv
// Combinational z = ((2*exp - 1) mod 2^64) >> min(s, 63) for the BerExp byte comparison.
module ber_exp_zcalc
  import ber_exp_pkg::*;
#(
  parameter int S_WIDTH = 8
) (
  input  logic [Z_WIDTH-1:0] exp_v,
  input  logic [S_WIDTH-1:0] s,
  output logic [Z_WIDTH-1:0] z
);

  logic [5:0]         s_c;
  logic [Z_WIDTH-1:0] twice_m1;

  // The doubling drops exp[63] and the decrement wraps, so exp = 2^63 yields all ones.
  always_comb begin
    s_c      = (s > S_WIDTH'(S_MAX)) ? 6'(S_MAX) : s[5:0];
    twice_m1 = (exp_v << 1) - Z_WIDTH'(1);
    z        = twice_m1 >> s_c;
  end

endmodule

// File: rtl/ber_exp_sampler.sv
// Falcon BerExp back end: lazy MSB-first byte-wise Bernoulli test of z against a random byte stream.
// Build option BER_EXP_CONST_TIME_EN: always consume all 8 bytes, keeping the first difference.
//
// state | meaning
// IDLE  | waiting for a job, din_rdy high
// ZCALC | forming z from the captured exp/s, byte index set to 7
// CMP   | consuming random bytes, comparing against z byte k (MSB first)
// OUT   | result valid, holding bit_o until dout_rdy
module ber_exp_sampler
  import ber_exp_pkg::*;
#(
  parameter int S_WIDTH = 8,
  parameter int Z_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_val,
  output logic               din_rdy,
  input  logic [63:0]        exp_i,
  input  logic [S_WIDTH-1:0] s_i,
  input  logic               rnd_val,
  output logic               rnd_rdy,
  input  logic [7:0]         rnd_byte,
  output logic               dout_val,
  input  logic               dout_rdy,
  output logic               bit_o
);

  generate
    if (Z_WIDTH != ber_exp_pkg::Z_WIDTH) begin : g_bad_z_width
      $error("ber_exp_sampler: Z_WIDTH must be 64");
    end
  endgenerate

  state_t       state;
  logic [63:0]  exp_r;
  logic [63:0]  z_r;
  logic [63:0]  z_calc;
  logic [S_WIDTH-1:0] s_r;
  logic [2:0]   k;
  logic [7:0]   zb;
`ifdef BER_EXP_CONST_TIME_EN
  logic         decided;
`endif

  ber_exp_zcalc #(.S_WIDTH(S_WIDTH)) u_zcalc (
    .exp_v (exp_r),
    .s     (s_r),
    .z     (z_calc)
  );

  assign zb      = z_r[{k, 3'b000} +: 8];
  assign din_rdy = rst_n && (state == IDLE);
  assign rnd_rdy = rst_n && (state == CMP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      exp_r    <= '0;
      s_r      <= '0;
      z_r      <= '0;
      k        <= '0;
      dout_val <= 1'b0;
      bit_o    <= 1'b0;
`ifdef BER_EXP_CONST_TIME_EN
      decided  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (din_val) begin
            exp_r <= exp_i;
            s_r   <= s_i;
            state <= ZCALC;
          end
        end
        ZCALC: begin
          z_r   <= z_calc;
          k     <= 3'(NUM_BYTES - 1);
          bit_o <= 1'b0;
`ifdef BER_EXP_CONST_TIME_EN
          decided <= 1'b0;
`endif
          state <= CMP;
        end
        CMP: begin
          if (rnd_val) begin
`ifdef BER_EXP_CONST_TIME_EN
            // Only the first differing byte decides; the rest are drained for fixed timing.
            if (!decided && (rnd_byte != zb)) begin
              decided <= 1'b1;
              bit_o   <= (rnd_byte < zb);
            end
            if (k == 3'd0) begin
              dout_val <= 1'b1;
              state    <= OUT;
            end else begin
              k <= k - 3'd1;
            end
`else
            if (rnd_byte < zb) begin
              bit_o    <= 1'b1;
              dout_val <= 1'b1;
              state    <= OUT;
            end else if ((rnd_byte > zb) || (k == 3'd0)) begin
              bit_o    <= 1'b0;
              dout_val <= 1'b1;
              state    <= OUT;
            end else begin
              k <= k - 3'd1;
            end
`endif
          end
        end
        OUT: begin
          if (dout_rdy) begin
            dout_val <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_exp_sampler.sv
// Directed self-checking bench for ber_exp_sampler with a spec-level BerExp model and per-cycle monitor.
module tb_ber_exp_sampler;

`ifdef BER_EXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        din_val;
  logic        din_rdy;
  logic [63:0] exp_i;
  logic [7:0]  s_i;
  logic        rnd_val;
  logic        rnd_rdy;
  logic [7:0]  rnd_byte;
  logic        dout_val;
  logic        dout_rdy;
  logic        bit_o;

  int errors = 0;
  int checks = 0;
  int job_bytes = 0;
  bit rnd_tog = 1'b0;
  logic [7:0] rnd_q[$];
  bit exp_bit_q[$];
  int exp_n_q[$];

  ber_exp_sampler #(.S_WIDTH(8), .Z_WIDTH(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_val  (din_val),
    .din_rdy  (din_rdy),
    .exp_i    (exp_i),
    .s_i      (s_i),
    .rnd_val  (rnd_val),
    .rnd_rdy  (rnd_rdy),
    .rnd_byte (rnd_byte),
    .dout_val (dout_val),
    .dout_rdy (dout_rdy),
    .bit_o    (bit_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // BerExp reference: z from plain arithmetic, then scan bytes MSB first for the first difference.
  function automatic void model(input logic [63:0] e, input logic [7:0] s, input logic [63:0] stream,
                                output bit b, output int n);
    logic [63:0] z;
    logic [7:0]  r;
    logic [7:0]  zz;
    int          sh;
    sh = (s > 8'd63) ? 63 : int'(s);
    z  = (e * 64'd2 - 64'd1) >> sh;
    b  = 1'b0;
    n  = 8;
    for (int i = 0; i < 8; i++) begin
      r  = stream[63 - 8*i -: 8];
      zz = z[63 - 8*i -: 8];
      if (r != zz) begin
        b = (r < zz);
        n = i + 1;
        break;
      end
    end
    if (CT) n = 8;
  endfunction

  // Random byte source: pops a byte after each accepted transfer.
  initial begin
    bit take;
    rnd_val  = 1'b1;
    rnd_byte = 8'h00;
    forever begin
      @(negedge clk);
      take = rnd_val && rnd_rdy;
      @(posedge clk);
      #1;
      if (take && rnd_q.size() > 0) void'(rnd_q.pop_front());
      rnd_val  = rnd_tog ? ~rnd_val : 1'b1;
      rnd_byte = (rnd_q.size() > 0) ? rnd_q[0] : 8'h00;
    end
  end

  // Per-cycle compare process.
  initial begin
    bit   prev_hold = 1'b0;
    logic prev_bit  = 1'b0;
    bit   eb;
    int   en;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk(!din_rdy && !rnd_rdy, "rdy_in_reset", {din_rdy, rnd_rdy}, 0);
        prev_hold = 1'b0;
      end else begin
        if (din_val && din_rdy) job_bytes = 0;
        if (rnd_val && rnd_rdy) job_bytes++;
        chk(!(din_rdy && rnd_rdy), "rdy_exclusive", {din_rdy, rnd_rdy}, 0);
        if (dout_val) chk(!din_rdy && !rnd_rdy, "rdy_in_out", {din_rdy, rnd_rdy}, 0);
        if (prev_hold) begin
          chk(dout_val == 1'b1, "dout_val_hold", dout_val, 1);
          chk(bit_o == prev_bit, "bit_o_hold", bit_o, prev_bit);
        end
        if (dout_val && dout_rdy) begin
          if (exp_bit_q.size() == 0) begin
            chk(1'b0, "unexpected_result", 1, 0);
          end else begin
            eb = exp_bit_q.pop_front();
            en = exp_n_q.pop_front();
            chk(bit_o == eb, "model_bit", bit_o, eb);
            chk(job_bytes == en, "model_bytes", job_bytes, en);
          end
        end
        prev_hold = dout_val && !dout_rdy;
        prev_bit  = bit_o;
      end
    end
  end

  task automatic run_job(input logic [63:0] e, input logic [7:0] s, input logic [63:0] stream,
                         input bit tog, input int hold, input bit lit_bit, input int lit_n, input int lit_lat);
    bit mb;
    int mn;
    int cyc;
    int n;
    model(e, s, stream, mb, mn);
    chk(mb == lit_bit, "pin_model_bit", mb, lit_bit);
    chk(mn == lit_n, "pin_model_bytes", mn, lit_n);
    for (int i = 0; i < 8; i++) rnd_q.push_back(stream[63 - 8*i -: 8]);
    exp_bit_q.push_back(mb);
    exp_n_q.push_back(mn);
    rnd_tog = tog;
    @(posedge clk); #1;
    din_val = 1'b1;
    exp_i   = e;
    s_i     = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!din_rdy && n < 20);
    if (!din_rdy) begin
      chk(1'b0, "din_timeout", n, 20);
      din_val = 1'b0;
      return;
    end
    @(posedge clk); #1;
    din_val = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!dout_val) chk(!din_rdy, "din_rdy_busy", din_rdy, 0);
    end while (!dout_val && cyc < 100);
    if (!dout_val) begin
      chk(1'b0, "dout_timeout", cyc, 100);
      return;
    end
    if (!tog) begin
      chk(cyc == 2 + mn, "latency_model", cyc, 2 + mn);
      chk(cyc == lit_lat, "latency_lit", cyc, lit_lat);
    end
    repeat (hold) begin
      @(negedge clk);
      chk(!din_rdy, "din_rdy_in_out", din_rdy, 0);
    end
    @(posedge clk); #1;
    dout_rdy = 1'b1;
    @(negedge clk);
    chk(bit_o == lit_bit, "bit_lit", bit_o, lit_bit);
    chk(job_bytes == lit_n, "bytes_lit", job_bytes, lit_n);
    @(posedge clk); #1;
    dout_rdy = 1'b0;
    @(negedge clk);
    chk(dout_val == 1'b0, "dout_val_drop", dout_val, 0);
    rnd_q.delete();
    rnd_tog = 1'b0;
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    din_val  = 1'b0;
    exp_i    = '0;
    s_i      = '0;
    dout_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(dout_val == 1'b0, "rst_dout_val", dout_val, 0);
    chk(bit_o == 1'b0, "rst_bit_o", bit_o, 0);
    chk(din_rdy == 1'b1, "rst_din_rdy", din_rdy, 1);
    chk(rnd_rdy == 1'b0, "rst_rnd_rdy", rnd_rdy, 0);

    // first byte below / above z's top byte 7F
    run_job(64'h4000_0000_0000_0000, 8'd0,   64'h0000_0000_0000_0000, 1'b0, 0, 1'b1, CT ? 8 : 1, CT ? 10 : 3);
    run_job(64'h4000_0000_0000_0000, 8'd0,   64'h8000_0000_0000_0000, 1'b0, 0, 1'b0, CT ? 8 : 1, CT ? 10 : 3);
    // s clamped to 63, wrap gives z = 1; last byte decides
    run_job(64'h8000_0000_0000_0000, 8'd200, 64'h0000_0000_0000_0000, 1'b0, 0, 1'b1, 8, 10);
    // z = 0, all bytes equal -> reject
    run_job(64'h4000_0000_0000_0000, 8'd63,  64'h0000_0000_0000_0000, 1'b0, 0, 1'b0, 8, 10);
    // z = 02468ACF13579BDD, third byte above
    run_job(64'h1234_5678_9ABC_DEF0, 8'd4,   64'h0246_8B00_0000_0000, 1'b0, 2, 1'b0, CT ? 8 : 3, CT ? 10 : 5);
    // z = 007FFFFF..., rnd_val toggling, output held 5 cycles
    run_job(64'h4000_0000_0000_0000, 8'd8,   64'h007F_8055_5555_5555, 1'b1, 5, 1'b1, CT ? 8 : 3, 0);

    // reset in the middle of CMP after 3 bytes
    for (int i = 0; i < 8; i++) rnd_q.push_back(8'h00);
    @(posedge clk); #1;
    din_val = 1'b1;
    exp_i   = 64'h4000_0000_0000_0000;
    s_i     = 8'd63;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!din_rdy && n < 20);
    @(posedge clk); #1;
    din_val = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (job_bytes < 3 && n < 50);
    chk(job_bytes == 3, "rst_job_reach3", job_bytes, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk(dout_val == 1'b0, "midrst_dout_val", dout_val, 0);
    chk(rnd_rdy == 1'b0, "midrst_rnd_rdy", rnd_rdy, 0);
    chk(din_rdy == 1'b1, "midrst_din_rdy", din_rdy, 1);
    repeat (3) @(negedge clk);
    #1;
    chk(job_bytes == 3, "midrst_no_more_bytes", job_bytes, 3);
    chk(dout_val == 1'b0, "midrst_no_result", dout_val, 0);
    rnd_q.delete();
    run_job(64'h4000_0000_0000_0000, 8'd0, 64'h0000_0000_0000_0000, 1'b0, 0, 1'b1, CT ? 8 : 1, CT ? 10 : 3);

    repeat (2) @(negedge clk);
    chk(exp_bit_q.size() == 0, "results_outstanding", exp_bit_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
